sprite_regfile: RTL and testbench
=================================

# sprite_regfile

Double-buffered sprite/background attribute store between the HPS Avalon-MM bus and the VGA renderer. Software writes sprite positions and the background colour into a shadow bank at any time. A commit request copies the shadow bank into the active bank at the next frame boundary, so the renderer never sees a half-updated frame. The renderer reads active attributes by sprite index through a registered one-cycle lookup port.

## Interface
Parameters:
- NUM_SPRITES, 16, number of sprite slots; legal range 1..64
- IDXW, $clog2(NUM_SPRITES) (minimum 1), width of the sprite index

Ports:
- clk  in  1  system clock, 50 MHz
- reset_n  in  1  reset; one clock; reset is asynchronous and active-low
- chipselect  in  1  Avalon slave select
- write  in  1  Avalon write strobe; a write occurs only when write=1 and chipselect=1
- address  in  7  Avalon word address
- writedata  in  32  Avalon write data
- read  in  1  Avalon read strobe (present only with SPRITE_READBACK_EN)
- readdata  out  32  Avalon read data, valid one cycle after read (only with SPRITE_READBACK_EN)
- frame_start  in  1  one-cycle pulse from the VGA counters at vcount=0, hcount=0
- rd_idx  in  IDXW  renderer lookup index
- rd_attr  out  32  active attributes of rd_idx, registered
- bg_rgb  out  24  active background colour {R,G,B}
- commit_done  out  1  one-cycle pulse when a copy completes
- busy  out  1  high while in ARMED or COPY

## Operation
Sprite word layout:
- [10:0] x
- [20:11] y
- [27:21] image id
- [31] enable
- [30:28] reserved; stored, ignored by the renderer

Address map:
- 0..NUM_SPRITES-1: shadow sprite word
- 7'h7E: shadow background colour, writedata[23:0]
- 7'h7F: control; writing writedata[0]=1 requests a commit
- All other addresses: writes ignored; reads return 0

Commit FSM states: IDLE, ARMED, COPY.
- IDLE → ARMED on a control write with bit0=1.
- ARMED → COPY on frame_start; the copy index resets to 0.
- COPY: each cycle copies shadow[idx] to active[idx] and increments idx. After idx=NUM_SPRITES-1, the next cycle copies shadow bg to active bg, pulses commit_done, then goes to IDLE.
- Total COPY duration: NUM_SPRITES+1 cycles.

Boundary and simultaneous-event rules:
- Commit request while ARMED: no effect.
- Commit request during COPY: sets the rearm flag. After COPY the FSM goes to ARMED instead of IDLE. commit_done still pulses.
- frame_start during COPY: ignored.
- Commit request and frame_start in the same cycle while IDLE: go to ARMED only. The copy waits for the next frame_start.
- Shadow write to index k in the same cycle COPY copies k: active[k] receives the pre-write shadow value; shadow[k] receives the new value.
- Shadow writes are always accepted in any state.

Reset values:
- All shadow and active sprite words: 0
- Shadow and active bg: 24'h000040
- rd_attr: 0; readdata: 0; commit_done: 0; busy: 0
- FSM: IDLE; rearm flag: 0
- Reset mid-COPY abandons the copy. Active contents return to reset values, with no partial commit retained.

## Timing
- rd_attr = active[rd_idx], registered: value presented in cycle n appears in cycle n+1.
- rd_idx ≥ NUM_SPRITES yields rd_attr = 0.
- Renderer prefetch budget: one cycle ahead.
- An active-bank update at cycle t is visible on rd_attr at cycle t+1 if rd_idx selects it.
- bg_rgb is a direct register output and changes in the cycle after the bg copy.
- commit_done is high in the same cycle that bg_rgb takes its new value.
- busy is registered: it rises the cycle after the commit request and falls with commit_done.
- Worst-case commit latency: one frame (840000 cycles) + NUM_SPRITES + 1.

## Configuration
SPRITE_READBACK_EN:
- Defined: read, readdata and read decode exist.
  - Sprite addresses return the shadow word.
  - 7'h7E returns {8'h0, shadow bg}.
  - 7'h7F returns {frame_cnt[15:0], 14'h0, copying, armed}.
  - frame_cnt is a 16-bit wrapping counter of frame_start pulses, reset 0.
- Undefined: the read port, readdata and frame_cnt are removed; the slave is write-only.

## Structure
- Shared package sprite_pkg:
  - sprite_attr_t packed struct (the word layout above)
  - commit_state_t enum
  - Address constants ADDR_BG=7'h7E, ADDR_CTRL=7'h7F
  - Reset constant BG_RESET=24'h000040
- One sub-module, sprite_commit_fsm: owns state, copy index, rearm flag, commit_done and busy. It outputs copy_en and copy_idx to the bank logic.

## Test plan
- Reset, then rd_idx=3 → rd_attr=0, bg_rgb=24'h000040, busy=0.
- Write sprite 2 = 32'h8000_5064, then control=1, then frame_start → busy=1 in the next cycle; commit_done pulses NUM_SPRITES+1 cycles after frame_start; then rd_idx=2 → rd_attr=32'h8000_5064 one cycle later.
- Write sprite 0 without a commit, over 3 frame_start pulses → rd_attr for index 0 stays 0 and busy stays 0.
- Control write during COPY → commit_done pulses, busy stays 1 in ARMED, and a second copy starts at the next frame_start.
- Write shadow[5] in the same cycle COPY handles index 5 → active[5] holds the old value; the next commit delivers the new value.
- Assert reset_n low mid-COPY (idx=7) → all active words 0, bg 24'h000040, FSM IDLE, no commit_done pulse.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite attribute store and its commit FSM.
package sprite_pkg;

  typedef struct packed {
    logic        enable;
    logic [2:0]  reserved;
    logic [6:0]  image_id;
    logic [9:0]  y;
    logic [10:0] x;
  } sprite_attr_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_COPY
  } commit_state_t;

  localparam logic [6:0]  ADDR_BG   = 7'h7E;
  localparam logic [6:0]  ADDR_CTRL = 7'h7F;
  localparam logic [23:0] BG_RESET  = 24'h000040;

endpackage

// File: rtl/sprite_commit_fsm.sv
// Commit sequencer: waits for a frame boundary, then walks the sprite slots and
// the background colour one per cycle, copying shadow into active.
module sprite_commit_fsm
  import sprite_pkg::*;
#(
  parameter int NUM_SPRITES = 16,
  parameter int IDXW        = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            commit_req,
  input  logic            frame_start,
  output logic            copy_en,
  output logic            copy_bg,
  output logic [IDXW-1:0] copy_idx,
  output logic            commit_done,
  output logic            busy
);

  commit_state_t   state;
  logic [IDXW:0]   idx;
  logic            rearm;

  // idx one past the last sprite is the background copy slot
  assign copy_bg  = (state == ST_COPY) && (idx == (IDXW+1)'(NUM_SPRITES));
  assign copy_en  = (state == ST_COPY) && !copy_bg;
  assign copy_idx = idx[IDXW-1:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      idx         <= '0;
      rearm       <= 1'b0;
      commit_done <= 1'b0;
      busy        <= 1'b0;
    end else begin
      commit_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (commit_req) begin
            state <= ST_ARMED;
            busy  <= 1'b1;
          end
        end
        ST_ARMED: begin
          if (frame_start) begin
            state <= ST_COPY;
            idx   <= '0;
          end
        end
        ST_COPY: begin
          if (copy_bg) begin
            commit_done <= 1'b1;
            rearm       <= 1'b0;
            // a request that arrived mid-copy needs a fresh frame of its own
            if (rearm || commit_req) begin
              state <= ST_ARMED;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            idx <= idx + (IDXW+1)'(1);
            if (commit_req) rearm <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/sprite_regfile.sv
// Double-buffered sprite/background attribute store between Avalon-MM and the renderer.
// Define SPRITE_READBACK_EN to add the Avalon read port, readdata and the frame counter.
module sprite_regfile
  import sprite_pkg::*;
#(
  parameter int NUM_SPRITES = 16,
  parameter int IDXW        = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            chipselect,
  input  logic            write,
  input  logic [6:0]      address,
  input  logic [31:0]     writedata,
`ifdef SPRITE_READBACK_EN
  input  logic            read,
  output logic [31:0]     readdata,
`endif
  input  logic            frame_start,
  input  logic [IDXW-1:0] rd_idx,
  output logic [31:0]     rd_attr,
  output logic [23:0]     bg_rgb,
  output logic            commit_done,
  output logic            busy
);

  sprite_attr_t    shadow [NUM_SPRITES];
  sprite_attr_t    active [NUM_SPRITES];
  logic [23:0]     shadow_bg;
  logic [23:0]     active_bg;
  logic            copy_en;
  logic            copy_bg;
  logic [IDXW-1:0] copy_idx;
  logic [31:0]     lookup;

  logic wr_en, sprite_wr, commit_req;
  assign wr_en      = chipselect && write;
  assign sprite_wr  = wr_en && (address < 7'(NUM_SPRITES));
  assign commit_req = wr_en && (address == ADDR_CTRL) && writedata[0];

  sprite_commit_fsm #(
    .NUM_SPRITES(NUM_SPRITES),
    .IDXW       (IDXW)
  ) u_fsm (
    .clk        (clk),
    .reset_n    (reset_n),
    .commit_req (commit_req),
    .frame_start(frame_start),
    .copy_en    (copy_en),
    .copy_bg    (copy_bg),
    .copy_idx   (copy_idx),
    .commit_done(commit_done),
    .busy       (busy)
  );

  // copy reads the pre-edge shadow, so a same-cycle write to that slot lands next commit
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
      shadow_bg <= BG_RESET;
      active_bg <= BG_RESET;
    end else begin
      if (sprite_wr) shadow[address[IDXW-1:0]] <= writedata;
      if (wr_en && (address == ADDR_BG)) shadow_bg <= writedata[23:0];
      if (copy_en) active[copy_idx] <= shadow[copy_idx];
      if (copy_bg) active_bg <= shadow_bg;
    end
  end

  always_comb begin
    lookup = '0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      if (rd_idx == IDXW'(i)) lookup = active[i];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rd_attr <= '0;
    else          rd_attr <= lookup;
  end

  assign bg_rgb = active_bg;

`ifdef SPRITE_READBACK_EN
  logic [15:0] frame_cnt;
  logic [31:0] read_mux;
  logic        copying, armed;

  // busy covers exactly ARMED and COPY, so ARMED is busy outside the copy walk
  assign copying = copy_en || copy_bg;
  assign armed   = busy && !copying;

  always_comb begin
    read_mux = '0;
    if (address < 7'(NUM_SPRITES)) read_mux = shadow[address[IDXW-1:0]];
    else if (address == ADDR_BG)   read_mux = {8'h0, shadow_bg};
    else if (address == ADDR_CTRL) read_mux = {frame_cnt, 14'h0, copying, armed};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt <= '0;
      readdata  <= '0;
    end else begin
      if (frame_start) frame_cnt <= frame_cnt + 16'd1;
      if (chipselect && read) readdata <= read_mux;
    end
  end
`endif

endmodule

// File: tb/tb_sprite_regfile.sv
// Directed self-checking bench for sprite_regfile (default build, write-only slave).
module tb_sprite_regfile;

  localparam int NUM_SPRITES = 16;
  localparam int IDXW        = 4;

  logic            clk         = 1'b0;
  logic            reset_n     = 1'b0;
  logic            chipselect  = 1'b0;
  logic            write       = 1'b0;
  logic [6:0]      address     = '0;
  logic [31:0]     writedata   = '0;
  logic            frame_start = 1'b0;
  logic [IDXW-1:0] rd_idx      = '0;
  logic [31:0]     rd_attr;
  logic [23:0]     bg_rgb;
  logic            commit_done;
  logic            busy;

  int   n_checks = 0;
  int   n_errors = 0;
  logic seen_done;

  sprite_regfile #(.NUM_SPRITES(NUM_SPRITES)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .chipselect (chipselect),
    .write      (write),
    .address    (address),
    .writedata  (writedata),
    .frame_start(frame_start),
    .rd_idx     (rd_idx),
    .rd_attr    (rd_attr),
    .bg_rgb     (bg_rgb),
    .commit_done(commit_done),
    .busy       (busy)
  );

  always #10 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic applyStimulus(input logic cs, input logic wr, input logic [6:0] addr,
                               input logic [31:0] data, input logic fs);
    chipselect  = cs;
    write       = wr;
    address     = addr;
    writedata   = data;
    frame_start = fs;
    tick();
    chipselect  = 1'b0;
    write       = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic bus_write(input logic [6:0] addr, input logic [31:0] data);
    applyStimulus(1'b1, 1'b1, addr, data, 1'b0);
  endtask

  task automatic frame_pulse();
    applyStimulus(1'b0, 1'b0, 7'h00, 32'h0, 1'b1);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rd_idx = 3;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    tick();
    checkOutput("reset_rd_attr", rd_attr, 32'h0);
    checkOutput("reset_bg", bg_rgb, 32'h000040);
    checkOutput("reset_busy", busy, 32'h0);
    checkOutput("reset_done", commit_done, 32'h0);

    // basic commit of sprite 2 and background
    bus_write(7'd2, 32'h8000_5064);
    bus_write(7'h7E, 32'h0012_3456);
    bus_write(7'h7F, 32'h1);
    checkOutput("busy_after_req", busy, 32'h1);
    run(3);
    checkOutput("busy_armed_wait", busy, 32'h1);
    checkOutput("no_done_armed", commit_done, 32'h0);
    frame_pulse();
    run(16);
    checkOutput("done_not_early", commit_done, 32'h0);
    checkOutput("bg_before_done", bg_rgb, 32'h000040);
    tick();
    checkOutput("done_pulse", commit_done, 32'h1);
    checkOutput("bg_with_done", bg_rgb, 32'h123456);
    checkOutput("busy_falls", busy, 32'h0);
    rd_idx = 2;
    tick();
    checkOutput("done_one_cycle", commit_done, 32'h0);
    checkOutput("rd_attr_idx2", rd_attr, 32'h8000_5064);
    rd_idx = 15;
    tick();
    checkOutput("rd_attr_idx15", rd_attr, 32'h0);

    // shadow writes without a commit never reach the active bank
    rd_idx = 0;
    bus_write(7'd0, 32'h0000_0ABC);
    applyStimulus(1'b0, 1'b1, 7'd2, 32'hFFFF_FFFF, 1'b0);
    bus_write(7'h40, 32'hDEAD_BEEF);
    for (int f = 0; f < 3; f++) begin
      frame_pulse();
      run(20);
    end
    checkOutput("no_commit_idx0", rd_attr, 32'h0);
    checkOutput("no_commit_busy", busy, 32'h0);

    // commit request during COPY rearms for the next frame
    bus_write(7'h7F, 32'h1);
    frame_pulse();
    run(2);
    bus_write(7'h7F, 32'h1);
    run(13);
    checkOutput("rearm_done_early", commit_done, 32'h0);
    tick();
    checkOutput("rearm_done_pulse", commit_done, 32'h1);
    checkOutput("rearm_busy_held", busy, 32'h1);
    checkOutput("rearm_idx0", rd_attr, 32'h0000_0ABC);
    bus_write(7'd0, 32'h0000_0DEF);
    run(5);
    checkOutput("rearm_waits_frame", rd_attr, 32'h0000_0ABC);
    checkOutput("rearm_busy_armed", busy, 32'h1);
    frame_pulse();
    run(16);
    checkOutput("second_done_early", commit_done, 32'h0);
    tick();
    checkOutput("second_done_pulse", commit_done, 32'h1);
    checkOutput("second_busy_falls", busy, 32'h0);
    checkOutput("second_idx0", rd_attr, 32'h0000_0DEF);
    rd_idx = 2;
    tick();
    checkOutput("cs_gated_write", rd_attr, 32'h8000_5064);

    // commit request and frame_start together while IDLE only arm
    bus_write(7'd2, 32'h4000_0002);
    applyStimulus(1'b1, 1'b1, 7'h7F, 32'h1, 1'b1);
    run(18);
    checkOutput("same_cycle_armed", busy, 32'h1);
    checkOutput("same_cycle_no_copy", rd_attr, 32'h8000_5064);
    frame_pulse();
    run(17);
    checkOutput("same_cycle_done", commit_done, 32'h1);
    checkOutput("same_cycle_idx2", rd_attr, 32'h4000_0002);

    // shadow write to slot 5 in the cycle COPY copies slot 5
    rd_idx = 5;
    bus_write(7'd5, 32'h1111_1111);
    bus_write(7'h7F, 32'h1);
    frame_pulse();
    run(5);
    bus_write(7'd5, 32'h2222_2222);
    run(10);
    tick();
    checkOutput("collide_done", commit_done, 32'h1);
    checkOutput("collide_old_value", rd_attr, 32'h1111_1111);
    bus_write(7'h7F, 32'h1);
    frame_pulse();
    run(17);
    checkOutput("collide_next_done", commit_done, 32'h1);
    checkOutput("collide_new_value", rd_attr, 32'h2222_2222);

    // reset in the middle of a copy (slot 7 pending)
    rd_idx = 2;
    bus_write(7'h7E, 32'h0000_FF00);
    bus_write(7'h7F, 32'h1);
    frame_pulse();
    run(7);
    reset_n = 1'b0;
    #1;
    checkOutput("midreset_bg", bg_rgb, 32'h000040);
    checkOutput("midreset_busy", busy, 32'h0);
    checkOutput("midreset_done", commit_done, 32'h0);
    checkOutput("midreset_rd_attr", rd_attr, 32'h0);
    tick();
    reset_n = 1'b1;
    tick();
    checkOutput("midreset_active2", rd_attr, 32'h0);
    seen_done = 1'b0;
    frame_pulse();
    repeat (20) begin
      tick();
      if (commit_done) seen_done = 1'b1;
    end
    checkOutput("midreset_no_done", seen_done, 32'h0);
    checkOutput("midreset_fsm_idle", busy, 32'h0);
    rd_idx = 5;
    tick();
    checkOutput("midreset_active5", rd_attr, 32'h0);
    bus_write(7'h7F, 32'h1);
    frame_pulse();
    run(17);
    checkOutput("post_reset_done", commit_done, 32'h1);
    checkOutput("post_reset_bg", bg_rgb, 32'h000040);
    checkOutput("post_reset_shadow5", rd_attr, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
